ex_mem_skid_reg: RTL and testbench
==================================

Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline boundary register with a valid/ready handshake on both sides.
- Accepts the execute-stage result beat, i.e. the consumer of the ID/EX register's outputs, and presents it to the memory stage.
- Two-entry skid buffer (main + skid), so in_ready is a registered signal with no combinational path from out_ready.
- Synchronous flush kills in-flight beats on a branch redirect.

Parameters:
- XLEN, 32, datapath width for pc, alu_result, store data.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous kill of all held and incoming beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  buffer can accept a beat this cycle.
- pc_in  in  XLEN  instruction PC.
- alu_result_in  in  XLEN  ALU result / memory address.
- store_data_in  in  XLEN  rs2 value for stores.
- rd_in  in  RD_W  destination register.
- funct3_in  in  3  memory access size/sign.
- mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  in  1 each  control bits.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  memory stage consumes the beat.
- pc_out, alu_result_out, store_data_out  out  XLEN  held payload.
- rd_out  out  RD_W  held payload.
- funct3_out  out  3  held payload.
- mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out  out  1 each  held control, forced 0 whenever out_valid=0.

Behaviour:
- Reset (async): state EMPTY; out_valid=0; in_ready=1; all payload outputs 0; all control outputs 0.
- Transfers: accept when in_valid & in_ready; deliver when out_valid & out_ready. Outputs are driven from the main register only.
- in_ready = !skid_valid, registered.
- Latency: an accepted beat appears on out_* the next cycle when the buffer is EMPTY or is delivering that cycle.
- FSM states (main_valid, skid_valid):
  - EMPTY(0,0):
    - accept -> BUSY, main<=in.
  - BUSY(1,0):
    - accept & deliver -> BUSY, main<=in.
    - accept & !deliver -> FULL, skid<=in, main unchanged.
    - !accept & deliver -> EMPTY.
    - otherwise hold.
  - FULL(1,1):
    - in_ready=0, in_valid ignored.
    - deliver -> BUSY, main<=skid.
    - otherwise hold.
- Ordering: strict FIFO; no beat is duplicated or lost except by flush.
- Payload stability: stable while out_valid & !out_ready.
- Flush:
  - Highest priority: -> EMPTY next cycle.
  - A beat delivered in the flush cycle still counts as delivered.
  - An incoming beat in the flush cycle is dropped.
  - in_ready=1 the cycle after flush.
- Control gating: control outputs read 0 when out_valid=0, so the memory stage never writes on a bubble. Payload data registers need not clear.
- Reset asserted mid-operation: immediate EMPTY, all outputs 0 regardless of clock.

Optional Feature:
- Macro: EX_MEM_PERF_EN.
- When defined:
  - Adds out ports stall_cycles (32) and flush_count (16).
  - stall_cycles increments each cycle out_valid & !out_ready.
  - flush_count increments each cycle flush=1 while any entry is valid.
  - Both saturate at all-ones and reset to 0.
- When undefined: ports and counters are absent; functional behaviour is otherwise identical.

Test Plan:
- Reset then stream 4 beats (alu_result 0x10,0x20,0x30,0x40) with out_ready=1 -> each appears 1 cycle after acceptance, in order; in_ready stays 1.
- Beat 0xA with out_ready=0, then beat 0xB -> FULL, in_ready=0 next cycle; beat 0xC is held upstream. out_ready=1 -> outputs 0xA, 0xB, then 0xC is accepted; no loss or duplication.
- FULL with beats 0x1/0x2, assert flush with in_valid=1 (0x3) -> next cycle out_valid=0, mem_write_out=0, in_ready=1; 0x3 is never output.
- Beat with mem_write_in=1, reg_write_in=1, rd_in=5, then out_valid drops -> mem_write_out/reg_write_out read 0 while empty.
- Assert reset asynchronously mid-stall in FULL -> out_valid=0 and all outputs 0 before the next clock edge; in_ready=1.
- With EX_MEM_PERF_EN: hold out_valid=1/out_ready=0 for 7 cycles, then flush once -> stall_cycles=7, flush_count=1.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register: two-entry skid buffer with valid/ready on both sides and a synchronous flush.
// Optional performance counters (stall_cycles, flush_count) are built when EX_MEM_PERF_EN is defined.
module ex_mem_skid_reg #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] alu_result_in,
   input  logic [XLEN-1:0] store_data_in,
   input  logic [RD_W-1:0] rd_in,
   input  logic [2:0]      funct3_in,
   input  logic            mem_read_in,
   input  logic            mem_write_in,
   input  logic            reg_write_in,
   input  logic            mem_to_reg_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] alu_result_out,
   output logic [XLEN-1:0] store_data_out,
   output logic [RD_W-1:0] rd_out,
   output logic [2:0]      funct3_out,
   output logic            mem_read_out,
   output logic            mem_write_out,
   output logic            reg_write_out,
   output logic            mem_to_reg_out
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [15:0]     flush_count
`endif
);

   // State encoding is {main_valid, skid_valid}
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] BUSY  = 2'b10;
   localparam logic [1:0] FULL  = 2'b11;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] store_data;
      logic [RD_W-1:0] rd;
      logic [2:0]      funct3;
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            mem_to_reg;
   } beat_t;

   logic [1:0] state_q, state_d;
   beat_t      main_q, main_d;
   beat_t      skid_q, skid_d;
   beat_t      in_beat_c;
   logic       accept_c;
   logic       deliver_c;

   // Control bits are cleared whenever main goes empty, so outputs stay purely registered.
   function automatic beat_t clear_ctrl(input beat_t b);
      beat_t r;
      r            = b;
      r.mem_read   = 1'b0;
      r.mem_write  = 1'b0;
      r.reg_write  = 1'b0;
      r.mem_to_reg = 1'b0;
      return r;
   endfunction

   assign in_beat_c = '{pc: pc_in, alu_result: alu_result_in, store_data: store_data_in,
                        rd: rd_in, funct3: funct3_in, mem_read: mem_read_in,
                        mem_write: mem_write_in, reg_write: reg_write_in,
                        mem_to_reg: mem_to_reg_in};
   assign accept_c  = in_valid & ~state_q[0];
   assign deliver_c = state_q[1] & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = clear_ctrl(main_q);
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept_c) begin
                  state_d = BUSY;
                  main_d  = in_beat_c;
               end
            end
            BUSY: begin
               if (accept_c && deliver_c) begin
                  main_d = in_beat_c;
               end else if (accept_c) begin
                  state_d = FULL;
                  skid_d  = in_beat_c;
               end else if (deliver_c) begin
                  state_d = EMPTY;
                  main_d  = clear_ctrl(main_q);
               end
            end
            FULL: begin
               if (deliver_c) begin
                  state_d = BUSY;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = clear_ctrl(main_q);
            end
         endcase
      end
   end

   assign in_ready       = ~state_q[0];
   assign out_valid      = state_q[1];
   assign pc_out         = main_q.pc;
   assign alu_result_out = main_q.alu_result;
   assign store_data_out = main_q.store_data;
   assign rd_out         = main_q.rd;
   assign funct3_out     = main_q.funct3;
   assign mem_read_out   = main_q.mem_read;
   assign mem_write_out  = main_q.mem_write;
   assign reg_write_out  = main_q.reg_write;
   assign mem_to_reg_out = main_q.mem_to_reg;

`ifdef EX_MEM_PERF_EN
   // Saturating counters: stalls seen by the memory stage, flushes that killed live beats.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (state_q[1] && !out_ready && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 32'(1);
         if (flush && (state_q != EMPTY) && (flush_count != '1))
            flush_count <= flush_count + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed vector table, corner sequences, random run vs a FIFO model.
module tb_ex_mem_skid_reg;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] pc_in, alu_result_in, store_data_in, pc_out, alu_result_out, store_data_out;
   logic [4:0]  rd_in, rd_out;
   logic [2:0]  funct3_in, funct3_out;
   logic        mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
   logic        mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_mem_skid_reg #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .rd_in(rd_in), .funct3_in(funct3_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_out(pc_out), .alu_result_out(alu_result_out), .store_data_out(store_data_out),
      .rd_out(rd_out), .funct3_out(funct3_out),
      .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out)
`ifdef EX_MEM_PERF_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        mr, mw, rw, mtr;
   } beat_t;

   typedef struct {
      logic        iv, ordy, fl, mw, rw;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        exp_ov, exp_ir, chk_alu;
      logic [31:0] exp_alu;
      logic [4:0]  exp_rd;
      logic        exp_mw, exp_rw;
   } vec_t;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic fl, input beat_t b);
      in_valid      = iv;
      out_ready     = ordy;
      flush         = fl;
      pc_in         = b.pc;
      alu_result_in = b.alu;
      store_data_in = b.sd;
      rd_in         = b.rd;
      funct3_in     = b.f3;
      mem_read_in   = b.mr;
      mem_write_in  = b.mw;
      reg_write_in  = b.rw;
      mem_to_reg_in = b.mtr;
   endtask

   function automatic beat_t simple_beat(input logic [31:0] alu, input logic mw, input logic rw,
                                         input logic [4:0] rd);
      beat_t b;
      b = '{pc: alu << 2, alu: alu, sd: ~alu, rd: rd, f3: 3'd2, mr: 1'b0, mw: mw, rw: rw, mtr: 1'b0};
      return b;
   endfunction

   function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                               input logic [31:0] alu, input logic mw, input logic rw,
                               input logic [4:0] rd, input logic exp_ov, input logic exp_ir,
                               input logic chk_alu, input logic [31:0] exp_alu,
                               input logic [4:0] exp_rd, input logic exp_mw, input logic exp_rw);
      vec_t v;
      v = '{iv: iv, ordy: ordy, fl: fl, mw: mw, rw: rw, alu: alu, rd: rd, exp_ov: exp_ov,
            exp_ir: exp_ir, chk_alu: chk_alu, exp_alu: exp_alu, exp_rd: exp_rd,
            exp_mw: exp_mw, exp_rw: exp_rw};
      return v;
   endfunction

   function automatic beat_t dut_beat();
      beat_t b;
      b = '{pc: pc_out, alu: alu_result_out, sd: store_data_out, rd: rd_out, f3: funct3_out,
            mr: mem_read_out, mw: mem_write_out, rw: reg_write_out, mtr: mem_to_reg_out};
      return b;
   endfunction

   vec_t  vecs[17];
   beat_t model_q[$];
   beat_t rb;

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      #1;
      check("reset_out_valid", 128'(out_valid), 128'(1'b0));
      check("reset_in_ready",  128'(in_ready),  128'(1'b1));
      check("reset_payload",   128'(dut_beat()), 128'(0));
      @(posedge clk); #1;
      reset = 1'b0;

      // Each row: inputs for one cycle, then expected outputs after the following edge.
      //              iv ordy fl alu   mw rw rd   ov ir chk exp_alu rd mw rw
      vecs[0]  = mk(1, 1, 0, 32'h10, 0, 0, 0,   1, 1, 1, 32'h10, 0, 0, 0);
      vecs[1]  = mk(1, 1, 0, 32'h20, 0, 0, 0,   1, 1, 1, 32'h20, 0, 0, 0);
      vecs[2]  = mk(1, 1, 0, 32'h30, 0, 0, 0,   1, 1, 1, 32'h30, 0, 0, 0);
      vecs[3]  = mk(1, 1, 0, 32'h40, 0, 0, 0,   1, 1, 1, 32'h40, 0, 0, 0);
      vecs[4]  = mk(0, 1, 0, 32'h0,  0, 0, 0,   0, 1, 0, 32'h0,  0, 0, 0);
      vecs[5]  = mk(1, 0, 0, 32'hA,  0, 0, 0,   1, 1, 1, 32'hA,  0, 0, 0);
      vecs[6]  = mk(1, 0, 0, 32'hB,  0, 0, 0,   1, 0, 1, 32'hA,  0, 0, 0);
      vecs[7]  = mk(1, 0, 0, 32'hC,  0, 0, 0,   1, 0, 1, 32'hA,  0, 0, 0);
      vecs[8]  = mk(1, 1, 0, 32'hC,  0, 0, 0,   1, 1, 1, 32'hB,  0, 0, 0);
      vecs[9]  = mk(1, 1, 0, 32'hC,  0, 0, 0,   1, 1, 1, 32'hC,  0, 0, 0);
      vecs[10] = mk(0, 1, 0, 32'h0,  0, 0, 0,   0, 1, 0, 32'h0,  0, 0, 0);
      vecs[11] = mk(1, 0, 0, 32'h1,  1, 0, 0,   1, 1, 1, 32'h1,  0, 1, 0);
      vecs[12] = mk(1, 0, 0, 32'h2,  1, 0, 0,   1, 0, 1, 32'h1,  0, 1, 0);
      vecs[13] = mk(1, 0, 1, 32'h3,  1, 0, 0,   0, 1, 0, 32'h0,  0, 0, 0);
      vecs[14] = mk(0, 1, 0, 32'h0,  0, 0, 0,   0, 1, 0, 32'h0,  0, 0, 0);
      vecs[15] = mk(1, 0, 0, 32'h50, 1, 1, 5,   1, 1, 1, 32'h50, 5, 1, 1);
      vecs[16] = mk(0, 1, 0, 32'h0,  0, 0, 0,   0, 1, 0, 32'h0,  0, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl,
               simple_beat(vecs[i].alu, vecs[i].mw, vecs[i].rw, vecs[i].rd));
         @(posedge clk); #1;
         check($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vecs[i].exp_ov));
         check($sformatf("vec%0d_in_ready", i),  128'(in_ready),  128'(vecs[i].exp_ir));
         check($sformatf("vec%0d_mem_write", i), 128'(mem_write_out), 128'(vecs[i].exp_mw));
         check($sformatf("vec%0d_reg_write", i), 128'(reg_write_out), 128'(vecs[i].exp_rw));
         if (vecs[i].chk_alu) begin
            check($sformatf("vec%0d_alu", i), 128'(alu_result_out), 128'(vecs[i].exp_alu));
            check($sformatf("vec%0d_rd", i),  128'(rd_out), 128'(vecs[i].exp_rd));
         end
      end

      // Asynchronous reset while stalled in FULL.
      drive(1'b1, 1'b0, 1'b0, simple_beat(32'h77, 1'b1, 1'b1, 5'd3));
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, simple_beat(32'h88, 1'b1, 1'b1, 5'd4));
      @(posedge clk); #1;
      check("full_before_reset_in_ready", 128'(in_ready), 128'(1'b0));
      check("full_before_reset_alu", 128'(alu_result_out), 128'(32'h77));
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_out_valid", 128'(out_valid), 128'(1'b0));
      check("async_reset_in_ready",  128'(in_ready),  128'(1'b1));
      check("async_reset_payload",   128'(dut_beat()), 128'(0));
      #2;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      @(posedge clk); #1;
      check("after_reset_out_valid", 128'(out_valid), 128'(1'b0));

`ifdef EX_MEM_PERF_EN
      reset = 1'b1;
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, simple_beat(32'h99, 1'b0, 1'b0, 5'd1));
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (7) begin
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b1, 1'b1, '0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0);
      check("perf_stall_cycles", 128'(stall_cycles), 128'(32'd7));
      check("perf_flush_count",  128'(flush_count),  128'(16'd1));
`endif

      // Random traffic against a capacity-2 FIFO model.
      model_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic iv, ordy, fl, acc, del;
         rb = '{pc: $urandom, alu: $urandom, sd: $urandom, rd: 5'($urandom),
                f3: 3'($urandom), mr: 1'($urandom), mw: 1'($urandom),
                rw: 1'($urandom), mtr: 1'($urandom)};
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 24) == 0);
         drive(iv, ordy, fl, rb);
         #1;
         check("rand_in_ready",  128'(in_ready),  128'(model_q.size() < 2));
         check("rand_out_valid", 128'(out_valid), 128'(model_q.size() > 0));
         if (model_q.size() > 0)
            check("rand_payload", 128'(dut_beat()), 128'(model_q[0]));
         else
            check("rand_ctrl_gated",
                  128'({mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out}), 128'(0));
         acc = iv && (model_q.size() < 2);
         del = ordy && (model_q.size() > 0);
         if (fl) begin
            model_q.delete();
         end else begin
            if (del) void'(model_q.pop_front());
            if (acc) model_q.push_back(rb);
         end
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
